// File: rtl/serial_quad_loader_pkg.sv
// Shared definitions for the serial quad loader: FSM states, the number of
// bits collected per load and the strobe counter width.
package serial_quad_pkg;

   localparam int unsigned BIT_COUNT = 4;
   localparam int unsigned STB_CNT_W = 4;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SHIFT = 3'd1,
      SETUP = 3'd2,
      STB12 = 3'd3,
      GAP   = 3'd4,
      STB34 = 3'd5,
      DONE  = 3'd6
   } state_t;

   // True for the two states that hold a latch enable high.
   function automatic logic is_strobe(input state_t s);
      return (s == STB12) || (s == STB34);
   endfunction

endpackage

// File: rtl/serial_quad_loader_if.sv
// Control, serial input and quad-latch output bundle of the loader.
interface serial_quad_loader_if;

   logic start;
   logic abort;
   logic sin;
   logic sin_valid;
   logic d1;
   logic d2;
   logic d3;
   logic d4;
   logic c12;
   logic c34;
   logic busy;
   logic done;

   modport master (
      output start, abort, sin, sin_valid,
      input  d1, d2, d3, d4, c12, c34, busy, done
   );

   modport slave (
      input  start, abort, sin, sin_valid,
      output d1, d2, d3, d4, c12, c34, busy, done
   );

endinterface

// File: rtl/serial_quad_loader_strobe_timer.sv
// Down-counter timing the latch-strobe width. Loaded with STROBE_W in the
// cycle before a strobe state, it flags the last strobe cycle and holds at
// one afterwards instead of wrapping.
module strobe_timer
   import serial_quad_pkg::*;
#(
   parameter int unsigned STROBE_W = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic tick,
   output logic expired
);

   localparam logic [STB_CNT_W-1:0] LOAD_VAL = STB_CNT_W'(STROBE_W);
   localparam logic [STB_CNT_W-1:0] ONE      = STB_CNT_W'(1);

   logic [STB_CNT_W-1:0] cnt;

   // Reload ahead of each strobe, count down while strobing, stop at one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= LOAD_VAL;
      end else if (tick && (cnt > ONE)) begin
         cnt <= cnt - ONE;
      end
   end

   // Last cycle of the current strobe.
   always_comb begin
      expired = (cnt == ONE);
   end

endmodule

// File: rtl/serial_quad_loader.sv
// Collects four qualified serial bits, presents them in parallel to a quad
// latch and then strobes the d1/d2 and d3/d4 latch enables in turn.
// Every output is a flop; control outputs are registered from next-state.
module serial_quad_loader
   import serial_quad_pkg::*;
#(
   parameter int unsigned STROBE_W = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   serial_quad_loader_if.slave   bus
);

   state_t                 state;
   state_t                 state_next;

   logic [1:0]             bit_cnt;
   logic [BIT_COUNT-2:0]   sr;
   logic [BIT_COUNT-1:0]   d_q;

   logic                   c12_q;
   logic                   c34_q;
   logic                   busy_q;
   logic                   done_q;
   logic                   c12_n;
   logic                   c34_n;
   logic                   busy_n;
   logic                   done_n;

   logic                   accept;
   logic                   last_bit;
   logic                   tmr_load;
   logic                   tmr_tick;
   logic                   tmr_expired;

   strobe_timer #(
      .STROBE_W (STROBE_W)
   ) u_strobe_timer (
      .clk     (clk),
      .rst     (rst),
      .load    (tmr_load),
      .tick    (tmr_tick),
      .expired (tmr_expired)
   );

   // Bit acceptance and strobe timer control decoded from the current state.
   always_comb begin
      accept   = (state == SHIFT) && bus.sin_valid;
      last_bit = accept && (bit_cnt == 2'(BIT_COUNT - 1));
      tmr_load = (state == SETUP) || (state == GAP);
      tmr_tick = is_strobe(state);
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state and next-cycle output values; abort overrides everything.
   always_comb begin
      state_next = state;
      if (bus.abort) begin
         state_next = IDLE;
      end else begin
         unique case (state)
            IDLE:    if (bus.start)   state_next = SHIFT;
            SHIFT:   if (last_bit)    state_next = SETUP;
            SETUP:                    state_next = STB12;
            STB12:   if (tmr_expired) state_next = GAP;
            GAP:                      state_next = STB34;
            STB34:   if (tmr_expired) state_next = DONE;
            DONE:                     state_next = IDLE;
            default:                  state_next = IDLE;
         endcase
      end

      c12_n  = (state_next == STB12);
      c34_n  = (state_next == STB34);
      done_n = (state_next == DONE);
      busy_n = (state_next != IDLE);
   end

   // Registered control outputs, so they line up with the state they describe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c12_q  <= 1'b0;
         c34_q  <= 1'b0;
         done_q <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         c12_q  <= c12_n;
         c34_q  <= c34_n;
         done_q <= done_n;
         busy_q <= busy_n;
      end
   end

   // Serial collection: the first bit ends in d1; the parallel word is only
   // written on the edge accepting the last bit, and not when aborted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt <= '0;
         sr      <= '0;
         d_q     <= '0;
      end else if (!bus.abort) begin
         if ((state == IDLE) && bus.start) begin
            bit_cnt <= '0;
            sr      <= '0;
         end else if (last_bit) begin
            d_q     <= {bus.sin, sr};
            bit_cnt <= '0;
         end else if (accept) begin
            sr      <= {bus.sin, sr[BIT_COUNT-2:1]};
            bit_cnt <= bit_cnt + 2'd1;
         end
      end
   end

   // Drive the bundle straight from the flops.
   always_comb begin
      bus.d1   = d_q[0];
      bus.d2   = d_q[1];
      bus.d3   = d_q[2];
      bus.d4   = d_q[3];
      bus.c12  = c12_q;
      bus.c34  = c34_q;
      bus.busy = busy_q;
      bus.done = done_q;
   end

endmodule

// File: tb/tb_serial_quad_loader.sv
// Randomized bench for serial_quad_loader: two instances (STROBE_W=1 and 3)
// share one stimulus stream and are compared against a timeline model.
module tb_serial_quad_loader;

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic abort;
   logic sin;
   logic sin_valid;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   logic [3:0]  model_d;

   serial_quad_loader_if bus1 ();
   serial_quad_loader_if bus3 ();

   assign bus1.start     = start;
   assign bus1.abort     = abort;
   assign bus1.sin       = sin;
   assign bus1.sin_valid = sin_valid;
   assign bus3.start     = start;
   assign bus3.abort     = abort;
   assign bus3.sin       = sin;
   assign bus3.sin_valid = sin_valid;

   serial_quad_loader #(.STROBE_W(1)) dut_w1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1.slave)
   );

   serial_quad_loader #(.STROBE_W(3)) dut_w3 (
      .clk (clk),
      .rst (rst),
      .bus (bus3.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected {c12,c34,done,busy} in the k-th cycle after the 4th-bit edge,
   // with everything low in the cycles after an abort sampled in cycle ka.
   function automatic logic [3:0] ref_ctl(input int w, input int k, input int ka);
      logic c12, c34, dn, by;
      if (ka >= 0 && k > ka) return 4'b0000;
      c12 = (k >= 1) && (k <= w);
      c34 = (k >= w + 2) && (k <= 2 * w + 1);
      dn  = (k == 2 * w + 2);
      by  = (k <= 2 * w + 2);
      return {c12, c34, dn, by};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_ctl(input string tag, input logic [3:0] e1, input logic [3:0] e3);
      check({tag, "/w1"}, 32'({bus1.c12, bus1.c34, bus1.done, bus1.busy}), 32'(e1));
      check({tag, "/w3"}, 32'({bus3.c12, bus3.c34, bus3.done, bus3.busy}), 32'(e3));
   endtask

   task automatic check_d(input string tag);
      check({tag, "/d_w1"}, 32'({bus1.d4, bus1.d3, bus1.d2, bus1.d1}), 32'(model_d));
      check({tag, "/d_w3"}, 32'({bus3.d4, bus3.d3, bus3.d2, bus3.d1}), 32'(model_d));
   endtask

   // bits[0] is the first serial bit (-> d1). gap<0 picks random idle gaps.
   // ka: -1 no abort, -2 abort on the 4th-bit edge, >=0 abort in cycle ka.
   task automatic run_load(input logic [3:0] bits, input int gap, input int ka, input bit noise);
      int g;
      start = 1'b1;
      step();
      start = 1'b0;
      check_ctl("start", 4'b0001, 4'b0001);
      for (int i = 0; i < 4; i++) begin
         g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
         for (int j = 0; j < g; j++) begin
            sin       = 1'($urandom);
            sin_valid = 1'b0;
            start     = 1'($urandom);
            step();
            start = 1'b0;
            check_d("hold");
         end
         sin       = bits[i];
         sin_valid = 1'b1;
         abort     = (ka == -2) && (i == 3);
         step();
         sin_valid = 1'b0;
         abort     = 1'b0;
      end
      if (ka == -2) begin
         check_ctl("abort4", 4'b0000, 4'b0000);
         check_d("abort4");
         return;
      end
      model_d = bits;
      check_d("load");
      for (int k = 0; k <= 9; k++) begin
         check_ctl($sformatf("seq k=%0d", k), ref_ctl(1, k, ka), ref_ctl(3, k, ka));
         abort     = (k == ka);
         start     = noise && (k <= 4) ? 1'($urandom) : 1'b0;
         sin       = 1'($urandom);
         sin_valid = 1'($urandom);
         step();
         abort     = 1'b0;
         start     = 1'b0;
         sin_valid = 1'b0;
      end
      check_d("after");
   endtask

   initial begin
      int r, ka;
      bit noise;
      rst       = 1'b1;
      start     = 1'b0;
      abort     = 1'b0;
      sin       = 1'b0;
      sin_valid = 1'b0;
      model_d   = 4'b0000;
      repeat (3) step();
      check_ctl("reset", 4'b0000, 4'b0000);
      check_d("reset");
      rst = 1'b0;
      step();

      // basic: bits 1,0,1,1 back to back
      run_load(4'b1101, 0, -1, 1'b0);
      // gapped: bits 0,1,1,0 with three idle cycles before each bit
      run_load(4'b0110, 3, -1, 1'b0);
      // start pulses while busy are ignored
      run_load(4'b1001, 0, -1, 1'b1);
      // abort during STB12, then a normal load
      run_load(4'($urandom), -1, 1, 1'b0);
      run_load(4'b0011, -1, -1, 1'b0);

      // abort together with start in IDLE
      start = 1'b1;
      abort = 1'b1;
      step();
      start = 1'b0;
      abort = 1'b0;
      check_ctl("abort_start", 4'b0000, 4'b0000);
      step();
      check_ctl("abort_start2", 4'b0000, 4'b0000);

      // abort on the 4th-bit edge keeps the old parallel word
      run_load(4'b1010, 0, -2, 1'b0);
      run_load(4'b0101, -1, -1, 1'b0);

      // async reset after two bits, then a fresh collection
      start = 1'b1;
      step();
      start     = 1'b0;
      sin       = 1'b1;
      sin_valid = 1'b1;
      step();
      sin       = 1'b0;
      step();
      sin_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      model_d = 4'b0000;
      check_ctl("async_rst", 4'b0000, 4'b0000);
      check_d("async_rst");
      step();
      rst = 1'b0;
      step();
      run_load(4'b1111, 0, -1, 1'b0);

      // randomized loads with occasional aborts and start noise
      for (int n = 0; n < 24; n++) begin
         r     = int'($urandom_range(0, 7));
         ka    = (r == 0) ? -2 : (r == 1) ? int'($urandom_range(0, 4)) : -1;
         noise = (ka == -1) ? 1'($urandom) : 1'b0;
         run_load(4'($urandom), -1, ka, noise);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
